// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decode/issue/writeback signal bundle for issue_scoreboard
// Rev 1.0
`default_nettype none

interface issue_scoreboard_if #(
  parameter int NUM_REGS  = 32,
  parameter int LAT_WIDTH = 3
);
  localparam int RW = $clog2(NUM_REGS);

  logic                 dec_valid;
  logic [RW-1:0]        dec_rs1;
  logic [RW-1:0]        dec_rs2;
  logic [RW-1:0]        dec_rd;
  logic                 dec_uses_rs1;
  logic                 dec_uses_rs2;
  logic                 dec_writes_rd;
  logic [LAT_WIDTH-1:0] dec_lat;
  logic                 flush;
  logic                 issue_valid;
  logic                 stall_decode;
  logic                 wb_valid;
  logic [RW-1:0]        wb_rd;
  logic                 busy;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    output dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_lat, flush,
    input  issue_valid, stall_decode, wb_valid, wb_rd, busy
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_lat, flush,
    output issue_valid, stall_decode, wb_valid, wb_rd, busy
  );
endinterface

`default_nettype wire

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: countdown RAW/WAW scoreboard with writeback-slot reservation ring
// Rev 1.0
`default_nettype none

module issue_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int LAT_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  issue_scoreboard_if.slave   sb
);
  localparam int RW    = $clog2(NUM_REGS);
  localparam int DEPTH = 2 ** LAT_WIDTH;

  logic [LAT_WIDTH-1:0] r_cnt     [NUM_REGS];
  logic [DEPTH-1:0]     r_sched;
  logic [RW-1:0]        r_slot_rd [DEPTH];

  logic [LAT_WIDTH-1:0] w_lat;
  logic [LAT_WIDTH-1:0] w_slot;
  logic                 w_wr;
  logic                 w_raw;
  logic                 w_waw;
  logic                 w_struct;
  logic                 w_clear;
  logic                 w_issue_valid;
  logic                 w_issue_wr;

  assign w_lat  = (sb.dec_lat == '0) ? LAT_WIDTH'(1) : sb.dec_lat;
  assign w_slot = w_lat - LAT_WIDTH'(1);
  assign w_wr   = sb.dec_writes_rd & (sb.dec_rd != '0);

  assign w_raw = (sb.dec_uses_rs1 & (sb.dec_rs1 != '0) & (r_cnt[sb.dec_rs1] != '0))
               | (sb.dec_uses_rs2 & (sb.dec_rs2 != '0) & (r_cnt[sb.dec_rs2] != '0));
  assign w_waw    = w_wr & (r_cnt[sb.dec_rd] != '0);
  // sched[L] is the slot that becomes sched[L-1] after this edge
  assign w_struct = w_wr & r_sched[w_lat];
  assign w_clear  = ~(w_raw | w_waw | w_struct) & ~sb.flush;

  // Issue/stall gated by rst so both read 0 while reset is held
  assign w_issue_valid   = rst & sb.dec_valid & w_clear;
  assign w_issue_wr      = w_issue_valid & w_wr;
  assign sb.issue_valid  = w_issue_valid;
  assign sb.stall_decode = rst & sb.dec_valid & ~w_clear;
  assign sb.wb_valid     = r_sched[0];
  assign sb.wb_rd        = r_sched[0] ? r_slot_rd[0] : '0;
  assign sb.busy         = |r_sched;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (sb.flush || (r == 0)) begin
          r_cnt[r] <= '0;
        end else if (w_issue_wr && (sb.dec_rd == RW'(r))) begin
          r_cnt[r] <= w_lat;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - LAT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sched <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        r_slot_rd[j] <= '0;
      end
    end else if (sb.flush) begin
      r_sched <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        r_slot_rd[j] <= '0;
      end
    end else begin
      r_sched <= {1'b0, r_sched[DEPTH-1:1]};
      for (int j = 0; j < DEPTH - 1; j++) begin
        r_slot_rd[j] <= r_slot_rd[j+1];
      end
      r_slot_rd[DEPTH-1] <= '0;
      // New reservation lands after the shift, overriding it for that slot
      if (w_issue_wr) begin
        r_sched[w_slot]   <= 1'b1;
        r_slot_rd[w_slot] <= sb.dec_rd;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: randomized + directed scoreboard bench for issue_scoreboard
// Rev 1.0
`default_nettype none

module tb_issue_scoreboard;
  logic clk;
  logic rst;

  issue_scoreboard_if #(.NUM_REGS(32), .LAT_WIDTH(3)) bus ();

  issue_scoreboard #(.NUM_REGS(32), .LAT_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int iss;
    int stall;
    int wbv;
    int wbrd;
    int busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference state: cycle each register is last written, and writeback cycle -> rd
  int   wr_cycle[32];
  int   wb_at[int];
  bit   flush_pend = 1'b0;

  task automatic chk(input string nm, input int c, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) wr_cycle[r] = -1;
    wb_at.delete();
    flush_pend = 1'b0;
  endtask

  task automatic check_zero_now(input string tag);
    chk({tag, "_issue_valid"},  cyc, int'(bus.issue_valid),  0);
    chk({tag, "_stall_decode"}, cyc, int'(bus.stall_decode), 0);
    chk({tag, "_wb_valid"},     cyc, int'(bus.wb_valid),     0);
    chk({tag, "_wb_rd"},        cyc, int'(bus.wb_rd),        0);
    chk({tag, "_busy"},         cyc, int'(bus.busy),         0);
  endtask

  task automatic step(input bit rv, input bit midr, input bit v, input bit u1, input bit u2,
                      input bit w, input int rs1, input int rs2, input int rd, input int lat,
                      input bit fl);
    exp_t e;
    int   ks[$];
    int   l;
    bit   wr, raw, waw, st, ok;
    @(posedge clk);
    #1;
    cyc++;
    if (flush_pend) begin
      for (int r = 0; r < 32; r++) wr_cycle[r] = -1;
      foreach (wb_at[k]) if (k >= cyc) ks.push_back(k);
      foreach (ks[i]) wb_at.delete(ks[i]);
      flush_pend = 1'b0;
    end
    bus.dec_valid     = v;
    bus.dec_uses_rs1  = u1;
    bus.dec_uses_rs2  = u2;
    bus.dec_writes_rd = w;
    bus.dec_rs1       = 5'(rs1);
    bus.dec_rs2       = 5'(rs2);
    bus.dec_rd        = 5'(rd);
    bus.dec_lat       = 3'(lat);
    bus.flush         = fl;
    rst               = rv;
    e = '{cyc: cyc, iss: 0, stall: 0, wbv: 0, wbrd: 0, busy: 0};
    if (!rv || midr) begin
      if (midr) begin
        #1 rst = 1'b0;
        #1 check_zero_now("async_rst");
      end
      model_reset();
    end else begin
      l   = (lat == 0) ? 1 : lat;
      wr  = w && (rd != 0);
      raw = (u1 && rs1 != 0 && cyc <= wr_cycle[rs1]) || (u2 && rs2 != 0 && cyc <= wr_cycle[rs2]);
      waw = wr && cyc <= wr_cycle[rd];
      st  = wr && wb_at.exists(cyc + l);
      ok  = !raw && !waw && !st && !fl;
      e.iss   = int'(v && ok);
      e.stall = int'(v && !ok);
      if (wb_at.exists(cyc)) begin
        e.wbv  = 1;
        e.wbrd = wb_at[cyc];
      end
      foreach (wb_at[k]) if (k >= cyc) e.busy = 1;
      if (v && ok && wr) begin
        wr_cycle[rd]  = cyc + l;
        wb_at[cyc + l] = rd;
      end
      if (fl) flush_pend = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_op(input int rd, input int lat);
    step(1, 0, 1, 0, 0, 1, 0, 0, rd, lat, 0);
  endtask

  task automatic rd_op(input int rs1, input bit fl);
    step(1, 0, 1, 1, 0, 0, rs1, 0, 0, 1, fl);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("issue_valid",  e.cyc, int'(bus.issue_valid),  e.iss);
      chk("stall_decode", e.cyc, int'(bus.stall_decode), e.stall);
      chk("wb_valid",     e.cyc, int'(bus.wb_valid),     e.wbv);
      chk("wb_rd",        e.cyc, int'(bus.wb_rd),        e.wbrd);
      chk("busy",         e.cyc, int'(bus.busy),         e.busy);
    end
  end

  initial begin
    bus.dec_valid = 1'b0;  bus.dec_uses_rs1 = 1'b0; bus.dec_uses_rs2 = 1'b0;
    bus.dec_writes_rd = 1'b0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
    bus.dec_lat = '0; bus.flush = 1'b0;
    model_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    bus.dec_valid = 1'b1; bus.dec_writes_rd = 1'b1; bus.dec_rd = 5'd5; bus.dec_lat = 3'd3;
    #1 check_zero_now("reset_hold");
    step(0, 0, 1, 0, 0, 1, 0, 0, 5, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic issue and writeback latency
    idle(1);
    wr_op(5, 3);
    idle(4);
    // RAW stall until the write has landed
    wr_op(5, 3);
    for (int i = 0; i < 4; i++) rd_op(5, 0);
    idle(3);
    // Writeback-slot collision
    wr_op(1, 3);
    wr_op(2, 2);
    wr_op(2, 2);
    idle(4);
    // x0 never reserves or blocks
    wr_op(0, 5);
    step(1, 0, 1, 1, 1, 1, 0, 0, 0, 2, 0);
    idle(6);
    // Flush kills the pending write and its hazard
    wr_op(7, 5);
    idle(1);
    rd_op(7, 1);
    rd_op(7, 0);
    idle(5);
    // Asynchronous reset mid-flight
    wr_op(3, 4);
    step(1, 1, 1, 1, 0, 0, 3, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wr_op(3, 2);
    idle(6);
    // Latency 0 behaves as 1, max latency 7
    wr_op(4, 0);
    rd_op(4, 0);
    rd_op(4, 0);
    wr_op(6, 7);
    wr_op(9, 7);
    idle(9);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1, 1, 1, 1, 1, 1, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), 0);
        step(0, 0, 1, 1, 0, 1, 1, 0, 2, 3, 0);
      end else begin
        step(1, 0, ($urandom_range(0, 9) < 7), $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 39) == 0));
      end
    end
    idle(10);

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue controller between the decode stage and the execute/writeback datapath. Per-register countdown scoreboard blocks read-after-write (RAW) and write-after-write (WAW) hazards. A writeback-slot reservation ring serialises completions onto the single register-file write port. The block drives the decode stall and sequences writeback (`wb_valid`/`wb_rd`), replacing per-pair opcode comparison with latency-aware tracking of all in-flight results.

## Interface
Parameters:
- `NUM_REGS`, 32, architectural registers; x0 is hard-wired zero.
- `LAT_WIDTH`, 3, width of the latency field; max latency is 2^LAT_WIDTH-1 (7).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decode presents an instruction.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  register indices.
- `dec_uses_rs1`, `dec_uses_rs2`, `dec_writes_rd`  in  1 each  operand/destination usage flags.
- `dec_lat`  in  LAT_WIDTH  cycles from issue to writeback; a value of 0 is treated as 1.
- `flush`  in  1  synchronous kill of all in-flight results.
- `issue_valid`  out  1  instruction issues this cycle.
- `stall_decode`  out  1  decode must hold its instruction.
- `wb_valid`  out  1  register write this cycle.
- `wb_rd`  out  5  register written.
- `busy`  out  1  any writeback is scheduled.

## Operation
State:
- `cnt[r]`: a LAT_WIDTH-bit countdown per register, r = 1..NUM_REGS-1.
- `sched[0..2^LAT_WIDTH-1]`: reservation bits; `sched[j]` = 1 means a writeback occurs j cycles from now.
- `slot_rd[j]`: destination index for slot j.

Definitions:
- `wr` = dec_writes_rd & (dec_rd != 0). Writes to x0 never reserve a slot.
- `L` = max(dec_lat, 1).
- RAW hazard: (dec_uses_rs1 & rs1 != 0 & cnt[rs1] != 0) | (the same test for rs2).
- WAW hazard: wr & cnt[dec_rd] != 0.
- Structural hazard: wr & sched[L].

Outputs:
- `issue_ready` = no hazard & !flush.
- `issue_valid` = dec_valid & issue_ready.
- `stall_decode` = dec_valid & !issue_ready.

Update on each clock edge:
- Every nonzero `cnt` decrements by 1.
- `sched` and `slot_rd` shift down one position (index j+1 moves to j; the top entry is cleared).
- On `issue_valid & wr`: `cnt[dec_rd]` <= L, `sched[L-1]` <= 1, `slot_rd[L-1]` <= dec_rd. These assignments override the decrement and shift for the entries involved.
- Non-writing instructions (for example stores) issue subject only to the RAW check and reserve nothing.

Writeback:
- `wb_valid` = sched[0]; `wb_rd` = slot_rd[0]; `wb_rd` = 0 when `wb_valid` is 0.
- `busy` = OR of all `sched` bits.

Flush:
- `flush` high suppresses issue in that cycle.
- On the next edge, all `cnt`, `sched` and `slot_rd` entries clear.
- `wb_valid` still reflects `sched[0]` during the flush cycle.

## Timing
- Reset (`rst` low, asynchronous): all `cnt`, `sched` and `slot_rd` entries are 0. `issue_valid`, `stall_decode`, `wb_valid`, `wb_rd` and `busy` are all 0 while reset is asserted, regardless of inputs.
- Issue is combinational, same cycle as `dec_valid` (0-cycle issue latency).
- An instruction issued at cycle t with latency L has `wb_valid` at cycle t+L.
- A dependent reader or rewriter of that register can issue no earlier than t+L+1. The cycle in which the register is written still counts as a hazard (no forwarding).
- At most one writeback per cycle, guaranteed by the `sched` check.
- When issue and writeback occur in the same cycle to different registers, both proceed.
- The same register cannot both issue and write back in the same cycle, because the WAW hazard blocks the issue.
- Asserting reset mid-flight discards every pending writeback with no `wb_valid` pulse. The first issue is possible in the first cycle after reset deasserts.

## Test plan
1. Reset release, then `dec_valid` with rd=5, L=3 at t=0 -> `issue_valid`=1 at t=0; `wb_valid`=1 with `wb_rd`=5 only at t=3; `busy`=1 during t=1..3.
2. RAW: rd=5, L=3 at t=0; at t=1 present rs1=5 -> `stall_decode`=1 for t=1..3, `issue_valid` at t=4.
3. Structural: A (rd=1, L=3) issues at t=0; B (rd=2, L=2) presented at t=1 -> B stalls at t=1 and issues at t=2; writebacks are rd=1 at t=3 and rd=2 at t=4.
4. x0 handling: rd=0, L=5 issues; next cycle rs1=0, rs2=0, rd=0 -> no stall, `busy` stays 0, no `wb_valid` ever.
5. Flush: rd=7, L=5 issues at t=0; `flush` at t=2 (with rs1=7 presented, `issue_valid`=0) -> no `wb_valid` at t=5; rs1=7 issues at t=3.
6. Asynchronous reset at t=1 after rd=3, L=4 issued at t=0 -> all outputs 0 immediately with no clock edge; no `wb_rd`=3 pulse after release.
